// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: decode-slot, forwarding-source and EX-side signals of the ID/EX stage
interface id_ex_stage_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 5,
  parameter int CWIDTH = 8
);
  logic              i_valid;
  logic [AWIDTH-1:0] i_rs_addr;
  logic [AWIDTH-1:0] i_rt_addr;
  logic [DWIDTH-1:0] i_rs_data;
  logic [DWIDTH-1:0] i_rt_data;
  logic [AWIDTH-1:0] i_waddr;
  logic [DWIDTH-1:0] i_imm;
  logic              i_reg_write;
  logic              i_mem_read;
  logic [CWIDTH-1:0] i_ctrl;
  logic              i_flush;
  logic              i_exm_reg_write;
  logic [AWIDTH-1:0] i_exm_waddr;
  logic [DWIDTH-1:0] i_exm_result;
  logic              i_wb_reg_write;
  logic [AWIDTH-1:0] i_wb_waddr;
  logic [DWIDTH-1:0] i_wb_data;
  logic              o_stall;
  logic              o_valid;
  logic [DWIDTH-1:0] o_rs_val;
  logic [DWIDTH-1:0] o_rt_val;
  logic [DWIDTH-1:0] o_imm;
  logic [AWIDTH-1:0] o_waddr;
  logic              o_reg_write;
  logic              o_mem_read;
  logic [CWIDTH-1:0] o_ctrl;
  logic [15:0]       o_stall_count;
  modport master (
    output i_valid, i_rs_addr, i_rt_addr, i_rs_data, i_rt_data, i_waddr, i_imm,
           i_reg_write, i_mem_read, i_ctrl, i_flush, i_exm_reg_write, i_exm_waddr,
           i_exm_result, i_wb_reg_write, i_wb_waddr, i_wb_data,
    input  o_stall, o_valid, o_rs_val, o_rt_val, o_imm, o_waddr, o_reg_write,
           o_mem_read, o_ctrl, o_stall_count
  );
  modport slave (
    input  i_valid, i_rs_addr, i_rt_addr, i_rs_data, i_rt_data, i_waddr, i_imm,
           i_reg_write, i_mem_read, i_ctrl, i_flush, i_exm_reg_write, i_exm_waddr,
           i_exm_result, i_wb_reg_write, i_wb_waddr, i_wb_data,
    output o_stall, o_valid, o_rs_val, o_rt_val, o_imm, o_waddr, o_reg_write,
           o_mem_read, o_ctrl, o_stall_count
  );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall, bubbles, EX operand forwarding and stall counter
module id_ex_stage #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 5,
  parameter int CWIDTH = 8
) (
  input logic         r_clk,
  input logic         r_rst,
  id_ex_stage_if.slave bus
);
  logic              valid, reg_write, mem_read, hazard, stall;
  logic [AWIDTH-1:0] rs_addr, rt_addr, waddr;
  logic [DWIDTH-1:0] rs_data, rt_data, imm;
  logic [CWIDTH-1:0] ctrl;
  logic [15:0]       stall_count;
  // hazard only looks at registered state and decode inputs, never at forwarded values
  assign hazard = bus.i_valid & valid & mem_read & (waddr == bus.i_rs_addr | waddr == bus.i_rt_addr);
  assign stall  = hazard & ~bus.i_flush;
  assign bus.o_rs_val = (bus.i_exm_reg_write && bus.i_exm_waddr == rs_addr) ? bus.i_exm_result :
                        (bus.i_wb_reg_write && bus.i_wb_waddr == rs_addr) ? bus.i_wb_data : rs_data;
  assign bus.o_rt_val = (bus.i_exm_reg_write && bus.i_exm_waddr == rt_addr) ? bus.i_exm_result :
                        (bus.i_wb_reg_write && bus.i_wb_waddr == rt_addr) ? bus.i_wb_data : rt_data;
  assign bus.o_stall       = stall;
  assign bus.o_valid       = valid;
  assign bus.o_imm         = imm;
  assign bus.o_waddr       = waddr;
  assign bus.o_reg_write   = reg_write & valid;
  assign bus.o_mem_read    = mem_read & valid;
  assign bus.o_ctrl        = ctrl;
  assign bus.o_stall_count = stall_count;
  always_ff @(posedge r_clk or negedge r_rst)
    if (!r_rst) begin
      valid       <= 1'b0;
      reg_write   <= 1'b0;
      mem_read    <= 1'b0;
      rs_addr     <= '0;
      rt_addr     <= '0;
      waddr       <= '0;
      rs_data     <= '0;
      rt_data     <= '0;
      imm         <= '0;
      ctrl        <= '0;
      stall_count <= '0;
    end else begin
      if (bus.i_flush || stall) begin
        valid     <= 1'b0;
        reg_write <= 1'b0;
        mem_read  <= 1'b0;
        ctrl      <= '0;
      end else begin
        valid     <= bus.i_valid;
        reg_write <= bus.i_valid & bus.i_reg_write;
        mem_read  <= bus.i_valid & bus.i_mem_read;
        rs_addr   <= bus.i_rs_addr;
        rt_addr   <= bus.i_rt_addr;
        waddr     <= bus.i_waddr;
        rs_data   <= bus.i_rs_data;
        rt_data   <= bus.i_rt_data;
        imm       <= bus.i_imm;
        ctrl      <= bus.i_ctrl;
      end
      if (stall && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: table-driven vectors plus hand-written load-use, flush, reset and saturation sequences
module tb_id_ex_stage;
  logic r_clk = 1'b0;
  logic r_rst = 1'b0;
  always #5 r_clk = ~r_clk;
  id_ex_stage_if bus ();
  id_ex_stage dut (.r_clk(r_clk), .r_rst(r_rst), .bus(bus));
  int total = 0;
  int bad = 0;
  typedef struct {
    logic v; logic [4:0] rs, rt; logic [31:0] rsd, rtd, imm; logic [4:0] wa;
    logic rw, mr; logic [7:0] ctrl;
    logic xw; logic [4:0] xa; logic [31:0] xd;
    logic ww; logic [4:0] wwa; logic [31:0] wd;
    logic e_v, e_rw, e_mr; logic [31:0] e_rs, e_rt;
  } vec_t;
  typedef struct {
    logic v, rw, mr; logic [31:0] rs, rt, imm; logic [4:0] wa; logic [7:0] ctrl;
  } exp_t;
  vec_t tv[10];
  exp_t sb[$];
  exp_t e;
  function automatic vec_t mk(
    input logic v, input logic [4:0] rs, rt, input logic [31:0] rsd, rtd, imm,
    input logic [4:0] wa, input logic rw, mr, input logic [7:0] ctrl,
    input logic xw, input logic [4:0] xa, input logic [31:0] xd,
    input logic ww, input logic [4:0] wwa, input logic [31:0] wd,
    input logic e_v, e_rw, e_mr, input logic [31:0] e_rs, e_rt);
    vec_t r;
    r.v = v; r.rs = rs; r.rt = rt; r.rsd = rsd; r.rtd = rtd; r.imm = imm; r.wa = wa;
    r.rw = rw; r.mr = mr; r.ctrl = ctrl; r.xw = xw; r.xa = xa; r.xd = xd;
    r.ww = ww; r.wwa = wwa; r.wd = wd; r.e_v = e_v; r.e_rw = e_rw; r.e_mr = e_mr;
    r.e_rs = e_rs; r.e_rt = e_rt;
    return r;
  endfunction
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", n, got, exp, $time);
    end
  endtask
  task automatic idle_id();
    bus.i_valid = 0; bus.i_rs_addr = 0; bus.i_rt_addr = 0; bus.i_rs_data = 0; bus.i_rt_data = 0;
    bus.i_waddr = 0; bus.i_imm = 0; bus.i_reg_write = 0; bus.i_mem_read = 0; bus.i_ctrl = 0;
    bus.i_flush = 0;
  endtask
  task automatic idle_fwd();
    bus.i_exm_reg_write = 0; bus.i_exm_waddr = 0; bus.i_exm_result = 0;
    bus.i_wb_reg_write = 0; bus.i_wb_waddr = 0; bus.i_wb_data = 0;
  endtask
  task automatic drive_id(input logic v, input logic [4:0] rs, rt, input logic [31:0] rsd, rtd, imm,
                          input logic [4:0] wa, input logic rw, mr, input logic [7:0] ctrl);
    bus.i_valid = v; bus.i_rs_addr = rs; bus.i_rt_addr = rt; bus.i_rs_data = rsd; bus.i_rt_data = rtd;
    bus.i_imm = imm; bus.i_waddr = wa; bus.i_reg_write = rw; bus.i_mem_read = mr; bus.i_ctrl = ctrl;
  endtask
  task automatic step();
    @(posedge r_clk);
    #1;
  endtask
  task automatic load_use();
    @(negedge r_clk);
    drive_id(1, 1, 2, 32'h1, 32'h2, 32'h0, 5'd8, 1, 1, 8'h11);
    step();
    drive_id(1, 8, 3, 32'h0, 32'h33, 32'h4, 5'd10, 1, 0, 8'h22);
    step();
    idle_id();
  endtask
  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    tv[0] = mk(1, 3, 4, 3, 4, 'h10, 9, 1, 0, 'hA5, 0, 0, 0, 0, 0, 0, 1, 1, 0, 3, 4);
    tv[1] = mk(1, 5, 6, 'h55, 'h66, 'h20, 11, 1, 0, 'h01, 1, 5, 'hDEAD, 0, 0, 0, 1, 1, 0, 'hDEAD, 'h66);
    tv[2] = mk(1, 5, 6, 'h55, 'h66, 'h21, 11, 1, 0, 'h02, 1, 5, 'hDEAD, 1, 5, 'hBEEF, 1, 1, 0, 'hDEAD, 'h66);
    tv[3] = mk(1, 1, 7, 'h11, 'h77, 'h22, 12, 0, 0, 'h03, 0, 0, 0, 1, 7, 'h1234, 1, 0, 0, 'h11, 'h1234);
    tv[4] = mk(1, 2, 7, 'h22, 'h77, 'h23, 13, 1, 0, 'h04, 0, 2, 'hFFFF, 0, 7, 'h5555, 1, 1, 0, 'h22, 'h77);
    tv[5] = mk(0, 4, 5, 'h44, 'h45, 'h24, 14, 1, 1, 'h05, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h44, 'h45);
    tv[6] = mk(1, 0, 0, 'h5, 'h6, 'h25, 0, 1, 0, 'h06, 1, 0, 'hAB, 1, 0, 'h99, 1, 1, 0, 'hAB, 'hAB);
    tv[7] = mk(1, 0, 9, 'h5, 'h6, 'h26, 15, 1, 0, 'h07, 0, 0, 0, 1, 0, 'h99, 1, 1, 0, 'h99, 'h6);
    tv[8] = mk(1, 10, 11, 'h1, 'h2, 'h27, 16, 0, 0, 'h08, 1, 11, 'hE1, 1, 10, 'hB1, 1, 0, 0, 'hB1, 'hE1);
    tv[9] = mk(1, 12, 13, 'hC, 'hD, 'h28, 8, 1, 1, 'h09, 0, 0, 0, 0, 0, 0, 1, 1, 1, 'hC, 'hD);
    idle_id();
    idle_fwd();
    #12;
    chk("rst_valid", {31'd0, bus.o_valid}, 0);
    chk("rst_stall", {31'd0, bus.o_stall}, 0);
    chk("rst_rs", bus.o_rs_val, 0);
    chk("rst_ctrl", {24'd0, bus.o_ctrl}, 0);
    chk("rst_count", {16'd0, bus.o_stall_count}, 0);
    @(negedge r_clk);
    r_rst = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge r_clk);
      idle_fwd();
      drive_id(tv[k].v, tv[k].rs, tv[k].rt, tv[k].rsd, tv[k].rtd, tv[k].imm, tv[k].wa, tv[k].rw, tv[k].mr, tv[k].ctrl);
      e.v = tv[k].e_v; e.rw = tv[k].e_rw; e.mr = tv[k].e_mr; e.rs = tv[k].e_rs; e.rt = tv[k].e_rt;
      e.imm = tv[k].imm; e.wa = tv[k].wa; e.ctrl = tv[k].ctrl;
      sb.push_back(e);
      #1 chk("tbl_stall", {31'd0, bus.o_stall}, 0);
      step();
      idle_id();
      bus.i_exm_reg_write = tv[k].xw; bus.i_exm_waddr = tv[k].xa; bus.i_exm_result = tv[k].xd;
      bus.i_wb_reg_write = tv[k].ww; bus.i_wb_waddr = tv[k].wwa; bus.i_wb_data = tv[k].wd;
      #1;
      e = sb.pop_front();
      chk($sformatf("tbl%0d_valid", k), {31'd0, bus.o_valid}, {31'd0, e.v});
      chk($sformatf("tbl%0d_rw", k), {31'd0, bus.o_reg_write}, {31'd0, e.rw});
      chk($sformatf("tbl%0d_mr", k), {31'd0, bus.o_mem_read}, {31'd0, e.mr});
      chk($sformatf("tbl%0d_rs", k), bus.o_rs_val, e.rs);
      chk($sformatf("tbl%0d_rt", k), bus.o_rt_val, e.rt);
      chk($sformatf("tbl%0d_imm", k), bus.o_imm, e.imm);
      chk($sformatf("tbl%0d_wa", k), {27'd0, bus.o_waddr}, {27'd0, e.wa});
      chk($sformatf("tbl%0d_ctrl", k), {24'd0, bus.o_ctrl}, {24'd0, e.ctrl});
    end
    @(negedge r_clk);
    idle_id();
    idle_fwd();
    step();
    @(negedge r_clk);
    drive_id(1, 1, 2, 32'h1, 32'h2, 32'h0, 5'd8, 1, 1, 8'h11);
    step();
    drive_id(1, 8, 3, 32'h0, 32'h33, 32'h4, 5'd10, 1, 0, 8'h22);
    #1 chk("lu_stall", {31'd0, bus.o_stall}, 1);
    step();
    chk("lu_bubble_valid", {31'd0, bus.o_valid}, 0);
    chk("lu_stall_once", {31'd0, bus.o_stall}, 0);
    chk("lu_count", {16'd0, bus.o_stall_count}, 1);
    bus.i_exm_reg_write = 1; bus.i_exm_waddr = 8; bus.i_exm_result = 32'hCAFE;
    step();
    chk("lu_cap_valid", {31'd0, bus.o_valid}, 1);
    chk("lu_cap_rs", bus.o_rs_val, 32'hCAFE);
    chk("lu_cap_rt", bus.o_rt_val, 32'h33);
    chk("lu_cap_count", {16'd0, bus.o_stall_count}, 1);
    @(negedge r_clk);
    idle_id();
    idle_fwd();
    drive_id(1, 1, 2, 32'h1, 32'h2, 32'h0, 5'd8, 1, 1, 8'h11);
    step();
    drive_id(1, 8, 3, 32'h0, 32'h33, 32'h4, 5'd10, 1, 0, 8'h22);
    bus.i_flush = 1;
    #1 chk("fl_stall", {31'd0, bus.o_stall}, 0);
    step();
    chk("fl_valid", {31'd0, bus.o_valid}, 0);
    chk("fl_rw", {31'd0, bus.o_reg_write}, 0);
    chk("fl_mr", {31'd0, bus.o_mem_read}, 0);
    chk("fl_ctrl", {24'd0, bus.o_ctrl}, 0);
    chk("fl_count", {16'd0, bus.o_stall_count}, 1);
    @(negedge r_clk);
    idle_id();
    drive_id(1, 1, 2, 32'h1, 32'h2, 32'h0, 5'd8, 1, 1, 8'h11);
    step();
    drive_id(1, 8, 3, 32'h0, 32'h33, 32'h4, 5'd10, 1, 0, 8'h22);
    #1 chk("mr_stall_pre", {31'd0, bus.o_stall}, 1);
    #1 r_rst = 0;
    #1;
    chk("mr_stall", {31'd0, bus.o_stall}, 0);
    chk("mr_valid", {31'd0, bus.o_valid}, 0);
    chk("mr_rw", {31'd0, bus.o_reg_write}, 0);
    chk("mr_mr", {31'd0, bus.o_mem_read}, 0);
    chk("mr_rs", bus.o_rs_val, 0);
    chk("mr_rt", bus.o_rt_val, 0);
    chk("mr_imm", bus.o_imm, 0);
    chk("mr_wa", {27'd0, bus.o_waddr}, 0);
    chk("mr_count", {16'd0, bus.o_stall_count}, 0);
    @(negedge r_clk);
    r_rst = 1;
    drive_id(1, 3, 4, 32'd3, 32'd4, 32'h0, 5'd9, 1, 0, 8'h0);
    step();
    idle_id();
    #1;
    chk("rr_valid", {31'd0, bus.o_valid}, 1);
    chk("rr_rs", bus.o_rs_val, 3);
    chk("rr_rt", bus.o_rt_val, 4);
    @(negedge r_clk);
    force dut.stall_count = 16'hFFFD;
    #1 release dut.stall_count;
    load_use();
    chk("sat_1", {16'd0, bus.o_stall_count}, 32'hFFFE);
    load_use();
    chk("sat_2", {16'd0, bus.o_stall_count}, 32'hFFFF);
    load_use();
    chk("sat_3", {16'd0, bus.o_stall_count}, 32'hFFFF);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
